// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style ranging sensor emulator: answers a qualified trigger pulse with
// an echo pulse whose width encodes the latched target distance.
module ultrasonic_echo_responder #(
  parameter int CYCLES_PER_US  = 50,
  parameter int MIN_TRIG_US    = 10,
  parameter int BURST_DELAY_US = 200,
  parameter int US_PER_CM      = 58,
  parameter int MAX_CM         = 400,
  parameter int NO_ECHO_US     = 38000,
  parameter int HOLDOFF_US     = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  input  logic       target_valid,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  localparam int TRIG_CYC = MIN_TRIG_US * CYCLES_PER_US;
  localparam int TW       = $clog2(TRIG_CYC + 1);
  localparam int PW       = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_BURST, S_ECHO, S_HOLD} state_t;

  state_t          r_state;
  logic            r_trig_m, r_trig_s, r_trig_d;
  logic [PW-1:0]   r_presc;
  logic [15:0]     r_us;
  logic [15:0]     r_nus;
  logic [TW-1:0]   r_wcnt;
  logic            r_echo, r_busy, r_trig_err;

  logic            w_rise, w_tick, w_done;
  logic [15:0]     w_lim, w_dist16, w_dclamp, w_prod, w_nus;

  assign w_rise = r_trig_s & ~r_trig_d;
  assign w_tick = (r_presc == PW'(CYCLES_PER_US - 1));

  always_comb begin
    w_lim = 16'(HOLDOFF_US);
    case (r_state)
      S_BURST: w_lim = 16'(BURST_DELAY_US);
      S_ECHO:  w_lim = r_nus;
      default: w_lim = 16'(HOLDOFF_US);
    endcase
  end

  assign w_done = w_tick && (r_us == w_lim - 16'd1);

  // Distance is only looked at on the cycle the trigger is accepted.
  assign w_dist16 = {7'd0, distance_cm};
  assign w_dclamp = (w_dist16 > 16'(MAX_CM)) ? 16'(MAX_CM) : w_dist16;
  assign w_prod   = w_dclamp * 16'(US_PER_CM);
  assign w_nus    = (!target_valid || distance_cm == 9'd0) ? 16'(NO_ECHO_US) : w_prod;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_trig_m   <= 1'b0;
      r_trig_s   <= 1'b0;
      r_trig_d   <= 1'b0;
      r_presc    <= '0;
      r_us       <= '0;
      r_nus      <= '0;
      r_wcnt     <= '0;
      r_echo     <= 1'b0;
      r_busy     <= 1'b0;
      r_trig_err <= 1'b0;
    end else begin
      r_trig_m   <= trig;
      r_trig_s   <= r_trig_m;
      r_trig_d   <= r_trig_s;
      r_trig_err <= 1'b0;
      if (w_tick) begin
        r_presc <= '0;
        r_us    <= r_us + 16'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      // Every transition below restarts the prescaler and the us counter.
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_TRIG;
            r_busy  <= 1'b1;
            r_wcnt  <= '0;
            r_presc <= '0;
            r_us    <= '0;
          end
        end
        S_TRIG: begin
          if (r_trig_s) begin
            if (r_wcnt != TW'(TRIG_CYC)) r_wcnt <= r_wcnt + TW'(1);
          end else begin
            r_presc <= '0;
            r_us    <= '0;
            // The rising-edge cycle was spent in IDLE, so the count is width-1.
            if (r_wcnt >= TW'(TRIG_CYC - 1)) begin
              r_nus   <= w_nus;
              r_state <= S_BURST;
            end else begin
              r_trig_err <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        S_BURST: begin
          if (w_done) begin
            r_state <= S_ECHO;
            r_echo  <= 1'b1;
            r_presc <= '0;
            r_us    <= '0;
          end
        end
        S_ECHO: begin
          if (w_done) begin
            r_state <= S_HOLD;
            r_echo  <= 1'b0;
            r_presc <= '0;
            r_us    <= '0;
          end
        end
        S_HOLD: begin
          if (w_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_presc <= '0;
            r_us    <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_echo  <= 1'b0;
        end
      endcase
    end
  end

  assign echo     = r_echo;
  assign busy     = r_busy;
  assign trig_err = r_trig_err;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Scoreboard bench for ultrasonic_echo_responder with shrunken timing parameters.
module tb_ultrasonic_echo_responder;

  localparam int CPU = 4;
  localparam int MIN = 3;
  localparam int BD  = 5;
  localparam int UPC = 3;
  localparam int MAXC = 40;
  localparam int NOE = 150;
  localparam int HO  = 6;
  localparam int TC  = MIN * CPU;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       trig;
  logic [8:0] distance_cm;
  logic       target_valid;
  logic       echo, busy, trig_err;

  ultrasonic_echo_responder #(
    .CYCLES_PER_US(CPU), .MIN_TRIG_US(MIN), .BURST_DELAY_US(BD), .US_PER_CM(UPC),
    .MAX_CM(MAXC), .NO_ECHO_US(NOE), .HOLDOFF_US(HO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .trig(trig), .distance_cm(distance_cm),
    .target_valid(target_valid), .echo(echo), .busy(busy), .trig_err(trig_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit acc;
    int w;
    int nus;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_nus(input int d, input bit v);
    if (!v || d == 0) return NOE;
    return ((d > MAXC) ? MAXC : d) * UPC;
  endfunction

  // Monitor: measures each busy episode and checks it against the queue head.
  int cyc = 0, t_br = 0, t_er = 0, t_ef = 0, errs = 0;
  bit prev_busy = 0, prev_echo = 0, seen_echo = 0;
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (!reset_n) begin
      prev_busy = 0; prev_echo = 0; seen_echo = 0; errs = 0;
    end else begin
      if (trig_err) errs++;
      if (busy && !prev_busy) begin t_br = cyc; seen_echo = 0; end
      if (echo && !prev_echo) begin t_er = cyc; seen_echo = 1; end
      if (!echo && prev_echo) t_ef = cyc;
      if (!busy && prev_busy) begin
        if (q.size() == 0) chk("unexpected_episode", 1, 0);
        else begin
          e = q.pop_front();
          if (e.acc) begin
            chk("echo_seen", int'(seen_echo), 1);
            chk("burst_delay", t_er - t_br, e.w + BD * CPU);
            chk("echo_width", t_ef - t_er, e.nus * CPU);
            chk("holdoff", cyc - t_ef, HO * CPU);
            chk("trig_err_acc", errs, 0);
          end else begin
            chk("echo_seen_rej", int'(seen_echo), 0);
            chk("busy_width_rej", cyc - t_br, e.w);
            chk("trig_err_rej", errs, 1);
          end
        end
        errs = 0;
      end
      prev_busy = busy;
      prev_echo = echo;
    end
  end

  task automatic pulse(input int w);
    @(negedge clock);
    trig = 1'b1;
    repeat (w) @(negedge clock);
    trig = 1'b0;
  endtask

  task automatic wait_for(input string tag, input bit is_busy, input bit val, input int lim);
    int n = 0;
    while (((is_busy ? busy : echo) !== val) && n < lim) begin
      @(negedge clock);
      n++;
    end
    if (n >= lim) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic shot(input int d, input bit v, input int w);
    exp_t e;
    distance_cm = 9'(d);
    target_valid = v;
    e.acc = (w >= TC);
    e.w = w;
    e.nus = exp_nus(d, v);
    q.push_back(e);
    pulse(w);
    wait_for("shot_idle", 1'b1, 1'b0, 5000);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    trig = 1'b0;
    distance_cm = 9'd5;
    target_valid = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_trig_err", int'(trig_err), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    shot(5, 1'b1, TC);
    shot(511, 1'b1, TC);
    shot(50, 1'b1, TC + 7);
    shot(100, 1'b0, TC);
    shot(0, 1'b1, TC);
    shot(5, 1'b1, TC - 1);
    shot(5, 1'b1, 3);
    shot(5, 1'b1, TC);

    // distance changes during BURST must not affect the pulse in flight
    begin
      exp_t e;
      distance_cm = 9'd10; target_valid = 1'b1;
      e.acc = 1; e.w = TC; e.nus = exp_nus(10, 1'b1);
      q.push_back(e);
      pulse(TC);
      repeat (8) @(negedge clock);
      distance_cm = 9'd40;
      target_valid = 1'b0;
      wait_for("latch_idle", 1'b1, 1'b0, 5000);
      repeat (3) @(negedge clock);
      target_valid = 1'b1;
    end

    // extra trigger mid-ECHO, then trig held high through HOLDOFF into IDLE
    begin
      exp_t e;
      distance_cm = 9'd20;
      e.acc = 1; e.w = TC; e.nus = exp_nus(20, 1'b1);
      q.push_back(e);
      pulse(TC);
      wait_for("mid_echo_rise", 1'b0, 1'b1, 5000);
      repeat (5) @(negedge clock);
      pulse(TC + 3);
      wait_for("mid_echo_fall", 1'b0, 1'b0, 5000);
      repeat (5) @(negedge clock);
      trig = 1'b1;
      wait_for("held_idle", 1'b1, 1'b0, 5000);
      repeat (20) @(negedge clock);
      chk("held_trig_no_restart", int'(busy), 0);
      trig = 1'b0;
      repeat (5) @(negedge clock);
      shot(7, 1'b1, TC);
    end

    // async reset mid-ECHO, then a clean trigger
    distance_cm = 9'd5;
    pulse(TC);
    wait_for("rst_echo_rise", 1'b0, 1'b1, 5000);
    repeat (10) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_echo", int'(echo), 0);
    chk("async_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_rst_busy", int'(busy), 0);
    shot(5, 1'b1, TC);

    repeat (5) @(negedge clock);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
